// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port 32x16 data memory.
// Each access runs IDLE -> ISSUE -> DONE and completes with a one-cycle ack to the winner.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              p_Clock,
  input  logic              p_Reset,
  input  logic              p_Req0,
  input  logic              p_We0,
  input  logic [ADDR_W-1:0] p_Addr0,
  input  logic [DATA_W-1:0] p_Data0,
  output logic              p_Ack0,
  input  logic              p_Req1,
  input  logic              p_We1,
  input  logic [ADDR_W-1:0] p_Addr1,
  input  logic [DATA_W-1:0] p_Data1,
  output logic              p_Ack1,
  output logic [DATA_W-1:0] p_RData,
  output logic              p_Busy,
  output logic              p_MemEnable,
  output logic [ADDR_W-1:0] p_MemAddr,
  output logic [DATA_W-1:0] p_MemIn,
  input  logic [DATA_W-1:0] p_MemOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  // NOTE: every signal gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (p_Req0 || p_Req1) begin
          // With both asking, the one not served last wins; otherwise whoever asks.
          sel_d   = (p_Req0 && p_Req1) ? ~last_q : p_Req1;
          we_d    = sel_d ? p_We1   : p_We0;
          addr_d  = sel_d ? p_Addr1 : p_Addr0;
          data_d  = sel_d ? p_Data1 : p_Data0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = DONE;
      DONE: begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge p_Clock) begin
    if (p_Reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Reset gates the enable directly so an aborted write never lands in memory.
  assign p_MemEnable = (state_q == ISSUE) && we_q && !p_Reset;
  assign p_MemAddr   = addr_q;
  assign p_MemIn     = data_q;
  assign p_Ack0      = (state_q == DONE) && !sel_q;
  assign p_Ack1      = (state_q == DONE) && sel_q;
  assign p_RData     = p_MemOut;
  assign p_Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 32x16 memory attached.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [4:0]  addr0, addr1;
  logic [15:0] data0, data1;
  logic        ack0, ack1, busy, mem_en;
  logic [15:0] rdata, mem_in, mem_out;
  logic [4:0]  mem_addr;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [32] = '{default: 16'h0000};

  always #5 clk = ~clk;

  // Memory macro: write when enabled, otherwise register the addressed word.
  initial mem_out = 16'h0000;
  always @(posedge clk) begin
    if (mem_en) mem[mem_addr] <= mem_in;
    else        mem_out       <= mem[mem_addr];
  end

  mem_arbiter dut (
    .p_Clock     (clk),
    .p_Reset     (rst),
    .p_Req0      (req0),
    .p_We0       (we0),
    .p_Addr0     (addr0),
    .p_Data0     (data0),
    .p_Ack0      (ack0),
    .p_Req1      (req1),
    .p_We1       (we1),
    .p_Addr1     (addr1),
    .p_Data1     (data1),
    .p_Ack1      (ack1),
    .p_RData     (rdata),
    .p_Busy      (busy),
    .p_MemEnable (mem_en),
    .p_MemAddr   (mem_addr),
    .p_MemIn     (mem_in),
    .p_MemOut    (mem_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input bit n, input bit on, input bit we,
                           input logic [4:0] a, input logic [15:0] d);
    if (n) begin
      req1 = on; we1 = we; addr1 = a; data1 = d;
    end else begin
      req0 = on; we0 = we; addr0 = a; data0 = d;
    end
  endtask

  // Single uncontended access with checks at every stage.
  task automatic access(input string tag, input bit n, input bit we,
                        input logic [4:0] a, input logic [15:0] d, input logic [15:0] exp_rd);
    drive_req(n, 1'b1, we, a, d);
    check({tag, " idle busy"}, busy, 0);
    step();
    check({tag, " issue busy"}, busy, 1);
    check({tag, " issue enable"}, mem_en, we);
    check({tag, " issue addr"}, mem_addr, a);
    if (we) check({tag, " issue memin"}, mem_in, d);
    check({tag, " issue no ack"}, {ack1, ack0}, 0);
    step();
    check({tag, " done ack"}, {ack1, ack0}, n ? 2'b10 : 2'b01);
    check({tag, " done enable"}, mem_en, 0);
    if (!we) check({tag, " done rdata"}, rdata, exp_rd);
    drive_req(n, 1'b0, 1'b0, 5'd0, 16'h0);
    step();
    check({tag, " back idle busy"}, busy, 0);
    check({tag, " back idle ack"}, {ack1, ack0}, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    drive_req(1'b1, 1'b0, 1'b0, 5'd0, 16'h0);
    step();
    step();
    rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset acks", {ack1, ack0}, 0);
    check("reset enable", mem_en, 0);
    check("reset memaddr", mem_addr, 0);
    check("reset memin", mem_in, 0);

    // 1: write then read back through requester 0
    access("t1 wr5", 1'b0, 1'b1, 5'd5, 16'hBEEF, 16'h0000);
    access("t1 rd5", 1'b0, 1'b0, 5'd5, 16'h0000, 16'hBEEF);

    // 2: simultaneous reads after reset, twice
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      drive_req(1'b0, 1'b1, 1'b0, 5'd5, 16'h0);
      drive_req(1'b1, 1'b1, 1'b0, 5'd9, 16'h0);
      step();
      check("t2 first issue addr", mem_addr, 5);
      step();
      check("t2 cycle3 ack", {ack1, ack0}, 2'b01);
      check("t2 cycle3 rdata", rdata, 16'hBEEF);
      drive_req(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
      step();
      check("t2 cycle4 idle", {busy, ack1, ack0}, 0);
      step();
      check("t2 second issue addr", mem_addr, 9);
      step();
      check("t2 cycle6 ack", {ack1, ack0}, 2'b10);
      check("t2 cycle6 rdata", rdata, 16'h0000);
      drive_req(1'b1, 1'b0, 1'b0, 5'd0, 16'h0);
      step();
      check("t2 end idle", busy, 0);
    end

    // 3: req1 held throughout, req0 pulses; grants go 1,0,1
    drive_req(1'b1, 1'b1, 1'b0, 5'd5, 16'h0);
    step();
    step();
    check("t3 grant a", {ack1, ack0}, 2'b10);
    drive_req(1'b0, 1'b1, 1'b0, 5'd9, 16'h0);
    step();
    step();
    check("t3 issue addr b", mem_addr, 9);
    step();
    check("t3 grant b", {ack1, ack0}, 2'b01);
    drive_req(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    step();
    step();
    step();
    check("t3 grant c", {ack1, ack0}, 2'b10);
    check("t3 grant c rdata", rdata, 16'hBEEF);
    drive_req(1'b1, 1'b0, 1'b0, 5'd0, 16'h0);
    step();

    // 4: inputs changed mid-access are ignored
    drive_req(1'b1, 1'b1, 1'b1, 5'd31, 16'h0001);
    step();
    addr1 = 5'd0;
    data1 = 16'hFFFF;
    #1;
    check("t4 latched addr", mem_addr, 31);
    check("t4 latched data", mem_in, 16'h0001);
    step();
    check("t4 ack", {ack1, ack0}, 2'b10);
    drive_req(1'b1, 1'b0, 1'b0, 5'd0, 16'h0);
    step();
    access("t4 rd31", 1'b1, 1'b0, 5'd31, 16'h0, 16'h0001);
    access("t4 rd0", 1'b1, 1'b0, 5'd0, 16'h0, 16'h0000);

    // 5: reset during ISSUE aborts the write with no ack
    drive_req(1'b0, 1'b1, 1'b1, 5'd7, 16'h1234);
    step();
    rst = 1'b1;
    #1;
    check("t5 enable gated", mem_en, 0);
    step();
    check("t5 aborted busy", busy, 0);
    check("t5 aborted ack", {ack1, ack0}, 0);
    drive_req(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    rst = 1'b0;
    step();
    check("t5 no late ack", {ack1, ack0}, 0);
    access("t5 rd7", 1'b0, 1'b0, 5'd7, 16'h0, 16'h0000);

    // Reset during DONE still shows the ack in that cycle
    drive_req(1'b0, 1'b1, 1'b0, 5'd5, 16'h0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("rst in done ack", {ack1, ack0}, 2'b01);
    drive_req(1'b0, 1'b0, 1'b0, 5'd0, 16'h0);
    step();
    rst = 1'b0;
    check("rst in done idle", busy, 0);

    // 6: ten idle cycles
    for (int i = 0; i < 10; i++) begin
      step();
      check("t6 idle", {busy, mem_en, ack1, ack0}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the single-port 32x16 data memory. The memory writes on posedge when enable=1; when enable=0 it updates its registered read output on posedge.
Two clients (e.g. fetch and load/store units) share the memory via req/ack handshakes; the arbiter serialises accesses and returns read data.
It sits between the clients and the memory macro and drives all memory inputs.

Parameters:
ADDR_W, 5, memory address width (32 words)
DATA_W, 16, memory word width

Ports:
p_Clock  input  1  system clock, all state on posedge
p_Reset  input  1  synchronous active-high reset
p_Req0  input  1  requester 0 access request, held until p_Ack0
p_We0  input  1  requester 0: 1=write, 0=read
p_Addr0  input  ADDR_W  requester 0 address
p_Data0  input  DATA_W  requester 0 write data
p_Ack0  output  1  one-cycle completion pulse to requester 0
p_Req1, p_We1, p_Addr1, p_Data1, p_Ack1  same as above for requester 1
p_RData  output  DATA_W  read data, valid in the cycle an ack is high for a read
p_Busy  output  1  1 when state != IDLE
p_MemEnable  output  1  memory write enable
p_MemAddr  output  ADDR_W  memory address
p_MemIn  output  DATA_W  memory write data
p_MemOut  input  DATA_W  memory registered read data

Behaviour:
- States: IDLE, ISSUE, DONE. Every access takes exactly 3 cycles, IDLE->ISSUE->DONE->IDLE. Peak throughput is 1 access per 3 cycles.
- IDLE: requests are sampled. If any p_ReqN=1, select a winner and latch its We, Addr and Data into internal regs (g_Sel, g_We, g_Addr, g_Data), then go to ISSUE. If no request, stay in IDLE.
- Arbitration: pointer r_Last holds the last granted requester (reset=1, so requester 0 wins first).
  - Both requesting: winner = !r_Last.
  - One requesting: that requester wins.
  - r_Last is updated to g_Sel on the DONE->IDLE transition.
- ISSUE:
  - p_MemAddr=g_Addr, p_MemIn=g_Data, p_MemEnable=g_We & !p_Reset.
  - The memory performs the write, or captures read data, at the end of this cycle.
- DONE:
  - p_AckN=1 for N=g_Sel only, for exactly one cycle.
  - p_RData is a combinational pass of p_MemOut, valid when !g_We.
  - For writes, p_RData is don't-care; the bench shall not check it.
- Outside ISSUE: p_MemEnable=0, p_MemAddr=g_Addr, p_MemIn=g_Data. Memory reads in these cycles are harmless.
- Request inputs are sampled only in IDLE. Changes to inputs during ISSUE or DONE are ignored because latched copies are used.
- A requester must drop req in the cycle after its ack. A req still high in IDLE is treated as a new request.
- Reset (sampled at posedge):
  - State goes to IDLE, r_Last=1, g_* regs=0.
  - p_Ack0=p_Ack1=0, p_Busy=0, p_MemEnable=0.
  - Reset high during ISSUE suppresses the write at that edge (enable gated by !p_Reset).
  - No ack is issued for an aborted access.
- Reset high during DONE: the ack in that cycle is still driven (combinational from state). The access is then considered complete.
- Address wrap: none. The full 0..31 range is legal; no bounds checking.

Test Plan:
1. Reset, then req0 write addr=5 data=0xBEEF. Expect p_Ack0 in cycle 3 after req and p_MemEnable=1 only in ISSUE. Then req0 read addr=5: p_RData=0xBEEF with p_Ack0.
2. req0 and req1 both reads, raised in the same cycle after reset. Expect requester 0 acked first (cycle 3), requester 1 acked at cycle 6. A second simultaneous pair yields 0 then 1 again, since r_Last=1 after the second grant.
3. Back-to-back: req1 held continuously while req0 pulses. Expect grants to alternate 1,0,1 with no requester acked twice in a row while the other waits.
4. Write req1 addr=31 data=0x0001. During ISSUE, change p_Addr1 to 0 and p_Data1 to 0xFFFF. Then read 31 -> expect 0x0001; read 0 -> expect 0x0000.
5. Write addr=7 data=0x1234 with p_Reset asserted during ISSUE. Expect no ack and state IDLE. Then a read of 7 returns 0x0000.
6. Idle with no requests for 10 cycles. Expect p_Busy=0, p_MemEnable=0, and both acks 0 throughout.
